// File: rtl/bitstat_pkg.sv
// rtl/bitstat_pkg.sv - shared state type, width helpers and summary record for bitstat_frame_accum
// Contents: bitstat_state_t, cw_of/nw_of/lw_of width functions, *_MAX record field limits, bitstat_rec_t.
package bitstat_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } bitstat_state_t;

    // Width of the per-frame popcount total.
    function automatic int cw_of(input int width, input int frame_len);
        return $clog2(width * frame_len + 1);
    endfunction

    // Width of the per-frame word counters.
    function automatic int nw_of(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Width of a per-word popcount / clog2 value.
    function automatic int lw_of(input int width);
        return $clog2(width + 1);
    endfunction

    // Record fields are sized for the largest legal configuration (WIDTH=64,
    // FRAME_LEN=256); the top level presents only the low bits it needs.
    localparam int CW_MAX = 15;
    localparam int NW_MAX = 9;
    localparam int LW_MAX = 7;

    typedef struct packed {
        logic [CW_MAX-1:0] ones_total;
        logic [NW_MAX-1:0] onehot_cnt;
        logic [NW_MAX-1:0] onehot0_cnt;
        logic [NW_MAX-1:0] unknown_cnt;
        logic [LW_MAX-1:0] max_clog2;
        logic [NW_MAX-1:0] words;
    } bitstat_rec_t;

endpackage

// File: rtl/bitstat_word.sv
// rtl/bitstat_word.sv - combinational per-word bit metrics
// Ports: data (WIDTH) in; popcount, clog2 (LW) out; onehot, onehot0, isunknown out.
module bitstat_word
    import bitstat_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int LW    = lw_of(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [LW-1:0]    popcount,
    output logic             onehot,
    output logic             onehot0,
    output logic             isunknown,
    output logic [LW-1:0]    clog2
);

    logic [WIDTH-1:0] data_m1;

    // Only bits that are definitely 1 count; X/Z bits contribute nothing.
    always_comb begin
        popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i] === 1'b1) begin
                popcount = popcount + LW'(1);
            end
        end
    end

    assign isunknown = $isunknown(data);
    assign onehot    = (popcount == LW'(1));
    assign onehot0   = (popcount <= LW'(1));

    // ceil(log2(v)) for v >= 2 is one more than the MSB index of v-1.
    assign data_m1 = data - WIDTH'(1);

    always_comb begin
        clog2 = '0;
        if (!isunknown && (data > WIDTH'(1))) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (data_m1[i]) begin
                    clog2 = LW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/bitstat_frame_accum.sv
// rtl/bitstat_frame_accum.sv - folds per-word bit metrics over a frame and reports one record per frame
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_last input stream;
//        out_valid/out_ready handshake with out_ones_total, out_onehot_cnt, out_onehot0_cnt,
//        out_unknown_cnt, out_max_clog2, out_words summary record.
module bitstat_frame_accum
    import bitstat_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int FRAME_LEN = 8,
    localparam int CW        = cw_of(WIDTH, FRAME_LEN),
    localparam int NW        = nw_of(FRAME_LEN),
    localparam int LW        = lw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ones_total,
    output logic [NW-1:0]    out_onehot_cnt,
    output logic [NW-1:0]    out_onehot0_cnt,
    output logic [NW-1:0]    out_unknown_cnt,
    output logic [LW-1:0]    out_max_clog2,
    output logic [NW-1:0]    out_words
);

    bitstat_state_t state_q, state_d;
    bitstat_rec_t   rec_q, rec_d;

    logic [LW-1:0] w_popcount;
    logic [LW-1:0] w_clog2;
    logic          w_onehot;
    logic          w_onehot0;
    logic          w_unknown;
    logic          accept;
    logic          consume;
    logic          frame_end;
    logic          unused_rec_bits;

    bitstat_word #(.WIDTH(WIDTH)) u_word (
        .data      (in_data),
        .popcount  (w_popcount),
        .onehot    (w_onehot),
        .onehot0   (w_onehot0),
        .isunknown (w_unknown),
        .clog2     (w_clog2)
    );

    // in_ready is a register that is 1 exactly while in ACCUM.
    assign accept  = in_valid && in_ready;
    assign consume = (state_q == REPORT) && out_ready;

    // Accumulator values after folding in the word currently on in_data.
    always_comb begin
        rec_d             = rec_q;
        rec_d.ones_total  = rec_q.ones_total + CW_MAX'(w_popcount);
        rec_d.onehot_cnt  = rec_q.onehot_cnt + NW_MAX'(w_onehot);
        rec_d.onehot0_cnt = rec_q.onehot0_cnt + NW_MAX'(w_onehot0);
        rec_d.unknown_cnt = rec_q.unknown_cnt + NW_MAX'(w_unknown);
        if (LW_MAX'(w_clog2) > rec_q.max_clog2) begin
            rec_d.max_clog2 = LW_MAX'(w_clog2);
        end
        rec_d.words       = rec_q.words + NW_MAX'(1);
    end

    // in_last on the FRAME_LEN-th word still ends just one frame.
    assign frame_end = accept && (in_last || (rec_d.words == NW_MAX'(FRAME_LEN)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (frame_end) state_d = REPORT;
            REPORT:  if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            rec_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ACCUM);
            out_valid <= (state_d == REPORT);
            if (consume) begin
                rec_q <= '0;
            end else if (accept) begin
                rec_q <= rec_d;
            end
        end
    end

    assign out_ones_total  = rec_q.ones_total[CW-1:0];
    assign out_onehot_cnt  = rec_q.onehot_cnt[NW-1:0];
    assign out_onehot0_cnt = rec_q.onehot0_cnt[NW-1:0];
    assign out_unknown_cnt = rec_q.unknown_cnt[NW-1:0];
    assign out_max_clog2   = rec_q.max_clog2[LW-1:0];
    assign out_words       = rec_q.words[NW-1:0];

    // Upper record bits stay zero for smaller configurations.
    assign unused_rec_bits = ^rec_q;

endmodule

// File: tb/tb_bitstat_frame_accum.sv
// tb/tb_bitstat_frame_accum.sv - scoreboard bench for bitstat_frame_accum (FRAME_LEN=4 and FRAME_LEN=1)
module tb_bitstat_frame_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: WIDTH=16, FRAME_LEN=4 (CW=7, NW=3, LW=5)
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [15:0] a_in_data;
    logic [6:0]  a_ones;
    logic [2:0]  a_oh, a_oh0, a_unk, a_words;
    logic [4:0]  a_mx;

    // Instance B: WIDTH=16, FRAME_LEN=1 (CW=5, NW=1, LW=5)
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [4:0]  b_ones;
    logic [0:0]  b_oh, b_oh0, b_unk, b_words;
    logic [4:0]  b_mx;

    bitstat_frame_accum #(.WIDTH(16), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ones_total(a_ones), .out_onehot_cnt(a_oh), .out_onehot0_cnt(a_oh0),
        .out_unknown_cnt(a_unk), .out_max_clog2(a_mx), .out_words(a_words)
    );

    bitstat_frame_accum #(.WIDTH(16), .FRAME_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ones_total(b_ones), .out_onehot_cnt(b_oh), .out_onehot0_cnt(b_oh0),
        .out_unknown_cnt(b_unk), .out_max_clog2(b_mx), .out_words(b_words)
    );

    typedef struct {
        int ones;
        int oh;
        int oh0;
        int unk;
        int mx;
        int words;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int ones, input int oh, input int oh0,
                                input int unk, input int mx, input int words);
        exp_t e;
        e.ones = ones; e.oh = oh; e.oh0 = oh0; e.unk = unk; e.mx = mx; e.words = words;
        return e;
    endfunction

    // Reference fold of one word, used for the frame whose stimulus carries X bits.
    function automatic exp_t fold(input exp_t e, input logic [15:0] w);
        int     pc = 0;
        int     c  = 0;
        longint v;
        for (int i = 0; i < 16; i++) if (w[i] === 1'b1) pc++;
        e.ones += pc;
        if (pc == 1) e.oh++;
        if (pc <= 1) e.oh0++;
        if ($isunknown(w)) begin
            e.unk++;
        end else begin
            v = longint'(w);
            while ((longint'(1) << c) < v) c++;
            if (c > e.mx) e.mx = c;
        end
        e.words++;
        return e;
    endfunction

    // Scoreboard monitors: every cycle a record is presented it must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_record", 1, 0);
            end else begin
                e = qa[0];
                chk("a_ones_total", longint'(a_ones), e.ones);
                chk("a_onehot_cnt", longint'(a_oh), e.oh);
                chk("a_onehot0_cnt", longint'(a_oh0), e.oh0);
                chk("a_unknown_cnt", longint'(a_unk), e.unk);
                chk("a_max_clog2", longint'(a_mx), e.mx);
                chk("a_words", longint'(a_words), e.words);
                if (a_out_ready) void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_record", 1, 0);
            end else begin
                e = qb[0];
                chk("b_ones_total", longint'(b_ones), e.ones);
                chk("b_onehot_cnt", longint'(b_oh), e.oh);
                chk("b_onehot0_cnt", longint'(b_oh0), e.oh0);
                chk("b_unknown_cnt", longint'(b_unk), e.unk);
                chk("b_max_clog2", longint'(b_mx), e.mx);
                chk("b_words", longint'(b_words), e.words);
                if (b_out_ready) void'(qb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_a(input logic [15:0] d, input logic last, input logic exp_end);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = last;
        while (!a_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        chk("a_out_valid_latency", longint'(a_out_valid), longint'(exp_end));
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_out_valid"}, longint'(a_out_valid), 0);
        chk({tag, "_in_ready"}, longint'(a_in_ready), 0);
        chk({tag, "_ones"}, longint'(a_ones), 0);
        chk({tag, "_onehot"}, longint'(a_oh), 0);
        chk({tag, "_onehot0"}, longint'(a_oh0), 0);
        chk({tag, "_unknown"}, longint'(a_unk), 0);
        chk({tag, "_max_clog2"}, longint'(a_mx), 0);
        chk({tag, "_words"}, longint'(a_words), 0);
    endtask

    logic [15:0] xw;
    exp_t        ex;
    logic [15:0] b_words_in [6];
    int          acc_cyc [6];
    int          cyc;
    int          k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_a_zero("reset");
        chk("reset_b_in_ready", longint'(b_in_ready), 0);
        chk("reset_b_out_valid", longint'(b_out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_in_ready_after_release", longint'(a_in_ready), 1);

        // Full frame ended by count.
        qa.push_back(mk(4, 2, 3, 0, 15, 4));
        send_a(16'h0001, 1'b0, 1'b0);
        send_a(16'h0003, 1'b0, 1'b0);
        send_a(16'h8000, 1'b0, 1'b0);
        send_a(16'h0000, 1'b0, 1'b1);

        // Single-word frame ended by in_last.
        qa.push_back(mk(4, 0, 0, 0, 8, 1));
        send_a(16'h00F0, 1'b1, 1'b1);

        // Word with an X bit followed by all-ones.
        xw = 16'b0000_0000_0000_x001;
        ex = fold(fold(mk(0, 0, 0, 0, 0, 0), xw), 16'hFFFF);
        qa.push_back(ex);
        send_a(xw, 1'b0, 1'b0);
        send_a(16'hFFFF, 1'b1, 1'b1);

        // Downstream stalls for 5 cycles while the next word waits.
        qa.push_back(mk(4, 4, 4, 0, 8, 4));
        send_a(16'h0002, 1'b0, 1'b0);
        send_a(16'h0004, 1'b0, 1'b0);
        send_a(16'h0010, 1'b0, 1'b0);
        a_out_ready = 1'b0;
        send_a(16'h0100, 1'b0, 1'b1);
        a_in_valid = 1'b1;
        a_in_data  = 16'h0000;
        repeat (5) begin
            chk("a_in_ready_stall", longint'(a_in_ready), 0);
            chk("a_out_valid_stall", longint'(a_out_valid), 1);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("a_out_valid_after_handshake", longint'(a_out_valid), 0);
        chk("a_in_ready_after_handshake", longint'(a_in_ready), 1);

        // Partial frame discarded by reset.
        send_a(16'h0000, 1'b0, 1'b0);
        send_a(16'h0003, 1'b0, 1'b0);
        chk("a_partial_ones_before_reset", longint'(a_ones), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_a_zero("midframe_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_in_ready_after_midframe_reset", longint'(a_in_ready), 1);

        qa.push_back(mk(10, 2, 3, 0, 14, 4));
        send_a(16'h00FF, 1'b0, 1'b0);
        send_a(16'h0001, 1'b0, 1'b0);
        send_a(16'h0000, 1'b0, 1'b0);
        send_a(16'h4000, 1'b0, 1'b1);

        // in_last coinciding with FRAME_LEN: one frame, no empty follow-up.
        qa.push_back(mk(8, 0, 0, 0, 2, 4));
        send_a(16'h0003, 1'b0, 1'b0);
        send_a(16'h0003, 1'b0, 1'b0);
        send_a(16'h0003, 1'b0, 1'b0);
        send_a(16'h0003, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("a_scoreboard_drained", longint'(qa.size()), 0);
        chk("a_no_empty_frame", longint'(a_out_valid), 0);

        // FRAME_LEN=1: back-to-back words, one record every second cycle.
        b_words_in = '{16'h0000, 16'h0001, 16'h0002, 16'h0007, 16'hFFFF, 16'h1000};
        qb.push_back(mk(0, 0, 1, 0, 0, 1));
        qb.push_back(mk(1, 1, 1, 0, 0, 1));
        qb.push_back(mk(1, 1, 1, 0, 1, 1));
        qb.push_back(mk(3, 0, 0, 0, 3, 1));
        qb.push_back(mk(16, 0, 0, 0, 16, 1));
        qb.push_back(mk(1, 1, 1, 0, 12, 1));
        cyc = 0;
        k   = 0;
        b_in_valid = 1'b1;
        b_in_data  = b_words_in[0];
        while (k < 6 && cyc < 100) begin
            if (b_in_ready) begin
                acc_cyc[k] = cyc;
                k++;
                @(posedge clk); #1;
                cyc++;
                if (k < 6) b_in_data = b_words_in[k];
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        b_in_valid = 1'b0;
        chk("b_all_accepted", longint'(k), 6);
        for (int i = 1; i < k; i++) chk("b_accept_spacing", longint'(acc_cyc[i] - acc_cyc[i-1]), 2);
        repeat (4) @(posedge clk);
        #1;
        chk("b_scoreboard_drained", longint'(qb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitstat_frame_accum.md
# bitstat_frame_accum

Streaming bit-statistics accumulator that sits directly upstream of the bit-math result consumers. It accepts a stream of WIDTH-bit vectors over a valid/ready handshake and computes per-word metrics: popcount ($countones), onehot, onehot0, isunknown and $clog2 of the word as unsigned. It folds these over a frame of FRAME_LEN words and presents one registered summary record per frame on an output valid/ready handshake. Its outputs feed the downstream checkers that compare against the combinational math-function stages.

## Interface
- WIDTH, 16: bits per input word; legal 2..64.
- FRAME_LEN, 8: words per frame; legal 1..256.
- Derived (package functions, not parameters): CW = $clog2(WIDTH*FRAME_LEN+1), NW = $clog2(FRAME_LEN+1), LW = $clog2(WIDTH+1).
- Clock: single clock `clk`. Reset: `rst_n`, synchronous, active-low.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input vector.
- in_last  in  1  early frame terminator; ignored unless in_valid && in_ready.
- out_valid  out  1  summary record valid.
- out_ready  in  1  downstream accepts the record.
- out_ones_total  out  CW  sum of popcounts over the frame.
- out_onehot_cnt  out  NW  words with exactly one bit set.
- out_onehot0_cnt  out  NW  words with at most one bit set.
- out_unknown_cnt  out  NW  words containing any X/Z bit.
- out_max_clog2  out  LW  maximum $clog2(word) over the frame.
- out_words  out  NW  words in the frame (1..FRAME_LEN).

## Operation
- FSM states: ACCUM, REPORT. Reset state: ACCUM.
- ACCUM: in_ready=1, out_valid=0. On each accept (in_valid && in_ready), update the accumulators:
  - ones += popcount
  - onehot/onehot0/unknown counters += 1 when the per-word flag is set
  - max_clog2 = max(max_clog2, clog2(word))
  - words += 1
- Frame end: the accepted word has in_last=1, or words reaches FRAME_LEN with this accept. Next state is REPORT.
- REPORT: in_ready=0, out_valid=1, all out_* stable. When out_ready=1, the record is consumed, all accumulators clear to 0 and the state returns to ACCUM.
- Per-word X/Z rules:
  - Only bits equal to 1 count toward popcount.
  - A word with any X/Z bit sets isunknown.
  - onehot/onehot0 evaluate on the 1-bit count only.
  - clog2 of a word with X/Z uses 0.
- clog2(0)=0, clog2(1)=0.
- All counters are sized so they cannot overflow at legal parameters; no saturation logic.
- Reset values: out_valid=0, every out_* data field=0, in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Reset asserted mid-frame or in REPORT discards the partial frame or record; no record is emitted.

## Timing
- in_ready is a registered function of state; there is no combinational path from in_valid or out_ready to in_ready.
- Latency: out_valid rises the cycle after the accepting edge of the frame-ending word.
- The output record is fully registered. out_* hold while out_valid && !out_ready.
- Throughput: FRAME_LEN accept cycles plus at least 1 REPORT cycle per frame. A word presented while in REPORT waits; the upstream must hold in_valid and in_data.
- Accept on the cycle REPORT exits: not possible. The first word of the next frame is accepted at the earliest one cycle after the out handshake.
- in_last on a word that also reaches FRAME_LEN: single frame end, no empty frame.
- FRAME_LEN=1: every accepted word produces a record.

## Structure
- Package `bitstat_pkg`:
  - state enum (ACCUM, REPORT)
  - width functions for CW/NW/LW
  - a packed struct `bitstat_rec_t` for the output record
- Sub-module `bitstat_word`: purely combinational per-word metrics (popcount, onehot, onehot0, isunknown, clog2) for WIDTH bits, instantiated once.
- Top level holds the FSM, the accumulators and the output register.

## Test plan
- WIDTH=16, FRAME_LEN=4, words 0x0001, 0x0003, 0x8000, 0x0000 -> record ones=4, onehot=2, onehot0=3, unknown=0, max_clog2=15, words=4; out_valid one cycle after the 4th accept.
- Word 0x00F0 with in_last=1 as first word -> ones=4, onehot=0, onehot0=0, max_clog2=8, words=1.
- Word 16'b0000_0000_0000_x001 then 0xFFFF with last -> unknown=1, ones=17, max_clog2=16, words=2.
- out_ready held low 5 cycles in REPORT with in_valid=1 -> in_ready stays 0, record stable; first new word accepted after the handshake.
- rst_n=0 after 2 accepts -> no record emitted, all outputs 0; next full frame reports words=4 with correct counts.
- FRAME_LEN=1, back-to-back in_valid with out_ready=1 -> one record per word, every second cycle.
